// File: rtl/stage_memory_pkg.sv
// Shared decode constants, FSM state encoding and small helpers for the
// memory-access stage and its lane aligner.
package stage_memory_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Stores and branches are the only opcodes with no destination register.
   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode != OPC_STORE) && (opcode != OPC_BRANCH);
   endfunction

   function automatic logic is_link(input logic [6:0] opcode);
      return (opcode == OPC_JAL) || (opcode == OPC_JALR);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store replication and strobes, access
// legality/alignment check, and load lane extraction with extension.
module mem_lane_align
   import stage_memory_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        fault,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] load_data
);

   logic        legal;
   logic        misaligned;
   logic [31:0] rshift;

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      legal      = 1'b0;
      misaligned = 1'b0;
      wdata      = '0;
      wstrb      = '0;

      if (is_load)
         legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      else if (is_store)
         legal = funct3 inside {F3_B, F3_H, F3_W};

      case (funct3[1:0])
         2'b01:   misaligned = addr_lo[0];
         2'b10:   misaligned = (addr_lo != 2'b00);
         default: misaligned = 1'b0;
      endcase

      fault = (is_load || is_store) && (!legal || misaligned);

      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               wdata = {4{store_data[7:0]}};
               wstrb = 4'b0001 << addr_lo;
            end
            2'b01: begin
               wdata = {2{store_data[15:0]}};
               wstrb = 4'b0011 << addr_lo;
            end
            2'b10: begin
               wdata = store_data;
               wstrb = 4'b1111;
            end
            default: begin
               wdata = '0;
               wstrb = '0;
            end
         endcase
      end
   end

   // Load side works from the registered access descriptor, not live ex_* inputs.
   always_comb begin
      rshift = rdata >> {ld_addr_lo, 3'b000};
      case (ld_funct3)
         F3_B:    load_data = {{24{rshift[7]}}, rshift[7:0]};
         F3_BU:   load_data = {24'h0, rshift[7:0]};
         F3_H:    load_data = {{16{rshift[15]}}, rshift[15:0]};
         F3_HU:   load_data = {16'h0, rshift[15:0]};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_memory.sv
// Memory-access stage: accepts execute results, runs a single-outstanding
// req/gnt/rvalid bus transaction for loads/stores, and registers one result per instruction.
module stage_memory
   import stage_memory_pkg::*;
#(
   parameter int          ADDR_W     = 32,
   parameter logic [31:0] RST_PC_SEQ = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [6:0]        ex_opcode,
   input  logic [2:0]        ex_funct3,
   input  logic [31:0]       ex_alu_data,
   input  logic [31:0]       ex_rs2_data,
   input  logic [31:0]       ex_pc_seq,
   input  logic [4:0]        ex_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic [31:0]       wb_pc_seq,
   output logic              wb_fault
);

   state_t      state;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic        pend_we;

   logic        is_load;
   logic        is_store;
   logic        rd_write;
   logic        fault;
   logic        accept;
   logic [31:0] al_wdata;
   logic [3:0]  al_wstrb;
   logic [31:0] al_load_data;

   assign is_load  = (ex_opcode == OPC_LOAD);
   assign is_store = (ex_opcode == OPC_STORE);
   assign rd_write = writes_rd(ex_opcode) && (ex_rd != 5'd0);
   assign ex_ready = (state == ST_IDLE) && (!wb_valid || wb_ready);
   assign accept   = ex_valid && ex_ready;

   mem_lane_align u_align (
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (ex_funct3),
      .addr_lo    (ex_alu_data[1:0]),
      .store_data (ex_rs2_data),
      .wdata      (al_wdata),
      .wstrb      (al_wstrb),
      .fault      (fault),
      .ld_funct3  (ld_funct3),
      .ld_addr_lo (ld_addr_lo),
      .rdata      (mem_rdata),
      .load_data  (al_load_data)
   );

   // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         ld_funct3  <= '0;
         ld_addr_lo <= '0;
         pend_we    <= 1'b0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_pc_seq  <= RST_PC_SEQ;
         wb_fault   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wb_valid && wb_ready)
                  wb_valid <= 1'b0;
               if (accept) begin
                  wb_rd     <= ex_rd;
                  wb_pc_seq <= ex_pc_seq;
                  if ((is_load || is_store) && !fault) begin
                     state      <= ST_REQ;
                     mem_req    <= 1'b1;
                     mem_we     <= is_store;
                     mem_addr   <= {ex_alu_data[ADDR_W-1:2], 2'b00};
                     mem_wdata  <= al_wdata;
                     mem_wstrb  <= al_wstrb;
                     ld_funct3  <= ex_funct3;
                     ld_addr_lo <= ex_alu_data[1:0];
                     pend_we    <= rd_write;
                     wb_data    <= ex_alu_data;
                  end else begin
                     // Non-memory ops and faulting accesses complete without touching the bus.
                     wb_valid <= 1'b1;
                     wb_fault <= fault;
                     wb_we    <= rd_write && !fault;
                     wb_data  <= (is_link(ex_opcode) && !fault) ? ex_pc_seq : ex_alu_data;
                  end
               end
            end

            ST_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (mem_we) begin
                     wb_valid <= 1'b1;
                     wb_we    <= 1'b0;
                     wb_fault <= 1'b0;
                     state    <= ST_HOLD;
                  end else begin
                     state <= ST_WAIT_R;
                  end
               end
            end

            ST_WAIT_R: begin
               if (mem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_we    <= pend_we;
                  wb_fault <= 1'b0;
                  wb_data  <= al_load_data;
                  state    <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (wb_ready) begin
                  wb_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: ALU/link results, store lanes, load
// extension, faults, writeback stalls, back-to-back issue and mid-transaction reset.
module tb_stage_memory;

   localparam logic [6:0] OP_ALU   = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [6:0]  ex_opcode = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_alu_data = '0;
   logic [31:0] ex_rs2_data = '0;
   logic [31:0] ex_pc_seq = '0;
   logic [4:0]  ex_rd = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        wb_valid;
   logic        wb_ready = 1'b1;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] wb_pc_seq;
   logic        wb_fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_memory #(.ADDR_W(32), .RST_PC_SEQ(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_alu_data(ex_alu_data), .ex_rs2_data(ex_rs2_data), .ex_pc_seq(ex_pc_seq), .ex_rd(ex_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_pc_seq(wb_pc_seq), .wb_fault(wb_fault)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [4:0] rd);
      ex_valid    = 1'b1;
      ex_opcode   = opc;
      ex_funct3   = f3;
      ex_alu_data = alu;
      ex_rs2_data = rs2;
      ex_pc_seq   = pc;
      ex_rd       = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({mem_req, mem_we, mem_wstrb, wb_valid, wb_we, wb_fault} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 000000000",
                  {mem_req, mem_we, mem_wstrb, wb_valid, wb_we, wb_fault});
      end
      checks++;
      if ({mem_addr, mem_wdata, wb_data, wb_pc_seq} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data got addr=%h wdata=%h wb_data=%h pc=%h expected zero",
                  mem_addr, mem_wdata, wb_data, wb_pc_seq);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (ex_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ex_ready got %b expected 1", ex_ready);
      end
   endtask

   task automatic test_alu();
      wb_ready = 1'b1;
      set_op(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 32'h0000_0008, 5'd5);
      step();
      ex_valid = 1'b0;
      checks++;
      if ({wb_valid, wb_we, wb_fault, wb_rd, mem_req} !== {3'b110, 5'd5, 1'b0}) begin
         errors++;
         $display("FAIL alu_ctrl got v=%b we=%b f=%b rd=%0d req=%b expected 1 1 0 5 0",
                  wb_valid, wb_we, wb_fault, wb_rd, mem_req);
      end
      checks++;
      if ({wb_data, wb_pc_seq} !== {32'h0000_1234, 32'h0000_0008}) begin
         errors++;
         $display("FAIL alu_data got data=%h pc=%h expected 00001234 00000008", wb_data, wb_pc_seq);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL alu_consumed got wb_valid=%b expected 0", wb_valid);
      end
   endtask

   task automatic test_store_byte();
      set_op(OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 5'd0);
      step();
      ex_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid} !==
             {2'b11, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000, 1'b0}) begin
            errors++;
            $display("FAIL sb_req_cycle%0d got req=%b we=%b addr=%h wdata=%h strb=%b v=%b expected 1 1 00000100 a5a5a5a5 1000 0",
                     k, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_valid);
         end
         if (k == 2) mem_gnt = 1'b1;
         step();
      end
      mem_gnt = 1'b0;
      checks++;
      if ({mem_req, wb_valid, wb_we, wb_fault, ex_ready} !== 5'b01000) begin
         errors++;
         $display("FAIL sb_done got req=%b v=%b we=%b f=%b ex_ready=%b expected 0 1 0 0 0",
                  mem_req, wb_valid, wb_we, wb_fault, ex_ready);
      end
      step();
      checks++;
      if ({wb_valid, ex_ready} !== 2'b01) begin
         errors++;
         $display("FAIL sb_idle got v=%b ex_ready=%b expected 0 1", wb_valid, ex_ready);
      end
   endtask

   task automatic test_store_lanes();
      logic [2:0]  f3_t   [2] = '{3'b001, 3'b010};
      logic [31:0] addr_t [2] = '{32'h0000_00A2, 32'h0000_0010};
      logic [31:0] rs2_t  [2] = '{32'h1234_ABCD, 32'hCAFE_F00D};
      logic [31:0] ea_t   [2] = '{32'h0000_00A0, 32'h0000_0010};
      logic [31:0] wd_t   [2] = '{32'hABCD_ABCD, 32'hCAFE_F00D};
      logic [3:0]  ws_t   [2] = '{4'b1100, 4'b1111};
      for (int i = 0; i < 2; i++) begin
         set_op(OP_STORE, f3_t[i], addr_t[i], rs2_t[i], 32'h0, 5'd3);
         step();
         ex_valid = 1'b0;
         checks++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, ea_t[i], wd_t[i], ws_t[i]}) begin
            errors++;
            $display("FAIL store_lane%0d got req=%b we=%b addr=%h wdata=%h strb=%b expected 1 1 %h %h %b",
                     i, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ea_t[i], wd_t[i], ws_t[i]);
         end
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         checks++;
         if ({mem_req, wb_valid, wb_we} !== 3'b010) begin
            errors++;
            $display("FAIL store_lane%0d_done got req=%b v=%b we=%b expected 0 1 0", i, mem_req, wb_valid, wb_we);
         end
         step();
      end
   endtask

   task automatic test_load_ext(input logic [2:0] f3, input logic [31:0] expected);
      set_op(OP_LOAD, f3, 32'h0000_0202, 32'h0, 32'h0000_0030, 5'd7);
      step();
      ex_valid = 1'b0;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {2'b10, 32'h0000_0200, 4'b0000}) begin
         errors++;
         $display("FAIL load_req_f3_%b got req=%b we=%b addr=%h strb=%b expected 1 0 00000200 0000",
                  f3, mem_req, mem_we, mem_addr, mem_wstrb);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      checks++;
      if ({mem_req, wb_valid} !== 2'b00) begin
         errors++;
         $display("FAIL load_gnt_f3_%b got req=%b v=%b expected 0 0", f3, mem_req, wb_valid);
      end
      step();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0080_FF00;
      step();
      mem_rvalid = 1'b0;
      checks++;
      if ({wb_valid, wb_we, wb_fault, wb_rd, wb_data} !== {3'b110, 5'd7, expected}) begin
         errors++;
         $display("FAIL load_ext_f3_%b got v=%b we=%b f=%b rd=%0d data=%h expected 1 1 0 7 %h",
                  f3, wb_valid, wb_we, wb_fault, wb_rd, wb_data, expected);
      end
      step();
   endtask

   task automatic test_fault();
      logic [6:0]  opc_t [4] = '{OP_LOAD, OP_LOAD, OP_STORE, OP_STORE};
      logic [2:0]  f3_t  [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
      logic [31:0] a_t   [4] = '{32'h0000_0302, 32'h0000_0300, 32'h0000_0300, 32'h0000_0301};
      for (int i = 0; i < 4; i++) begin
         set_op(opc_t[i], f3_t[i], a_t[i], 32'hFFFF_FFFF, 32'h0, 5'd9);
         step();
         ex_valid = 1'b0;
         checks++;
         if ({mem_req, wb_valid, wb_we, wb_fault, wb_data} !== {4'b0101, a_t[i]}) begin
            errors++;
            $display("FAIL fault%0d got req=%b v=%b we=%b f=%b data=%h expected 0 1 0 1 %h",
                     i, mem_req, wb_valid, wb_we, wb_fault, wb_data, a_t[i]);
         end
         step();
      end
   endtask

   task automatic test_load_stall();
      wb_ready = 1'b0;
      set_op(OP_LOAD, 3'b001, 32'h0000_0402, 32'h0, 32'h0000_0050, 5'd3);
      step();
      ex_valid = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8001_1234;
      step();
      mem_rvalid = 1'b0;
      set_op(OP_ALU, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 5'd4);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({wb_valid, wb_we, wb_fault, wb_rd, wb_data, wb_pc_seq, ex_ready} !==
             {3'b110, 5'd3, 32'hFFFF_8001, 32'h0000_0050, 1'b0}) begin
            errors++;
            $display("FAIL lh_stall%0d got v=%b we=%b f=%b rd=%0d data=%h pc=%h ex_ready=%b expected 1 1 0 3 ffff8001 00000050 0",
                     k, wb_valid, wb_we, wb_fault, wb_rd, wb_data, wb_pc_seq, ex_ready);
         end
         step();
      end
      ex_valid = 1'b0;
      wb_ready = 1'b1;
      #1;
      checks++;
      if (ex_ready !== 1'b0) begin
         errors++;
         $display("FAIL lh_hold_ready got %b expected 0", ex_ready);
      end
      step();
      checks++;
      if ({wb_valid, ex_ready} !== 2'b01) begin
         errors++;
         $display("FAIL lh_release got v=%b ex_ready=%b expected 0 1", wb_valid, ex_ready);
      end
      set_op(OP_ALU, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 5'd4);
      step();
      ex_valid = 1'b0;
      checks++;
      if ({wb_valid, wb_we, wb_rd, wb_data} !== {2'b11, 5'd4, 32'h0000_0055}) begin
         errors++;
         $display("FAIL lh_next_op got v=%b we=%b rd=%0d data=%h expected 1 1 4 00000055",
                  wb_valid, wb_we, wb_rd, wb_data);
      end
      step();
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b0;
      set_op(OP_ALU, 3'b000, 32'h0000_1111, 32'h0, 32'h0, 5'd6);
      step();
      set_op(OP_JAL, 3'b000, 32'h0000_9999, 32'h0, 32'h0000_0044, 5'd1);
      step();
      checks++;
      if ({wb_valid, wb_rd, wb_data, ex_ready} !== {1'b1, 5'd6, 32'h0000_1111, 1'b0}) begin
         errors++;
         $display("FAIL b2b_stall got v=%b rd=%0d data=%h ex_ready=%b expected 1 6 00001111 0",
                  wb_valid, wb_rd, wb_data, ex_ready);
      end
      wb_ready = 1'b1;
      #1;
      checks++;
      if (ex_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got %b expected 1", ex_ready);
      end
      step();
      checks++;
      if ({wb_valid, wb_we, wb_rd, wb_data} !== {2'b11, 5'd1, 32'h0000_0044}) begin
         errors++;
         $display("FAIL b2b_jal got v=%b we=%b rd=%0d data=%h expected 1 1 1 00000044",
                  wb_valid, wb_we, wb_rd, wb_data);
      end
      set_op(OP_JALR, 3'b000, 32'h0000_0007, 32'h0, 32'h0000_0048, 5'd0);
      step();
      ex_valid = 1'b0;
      checks++;
      if ({wb_valid, wb_we, wb_data} !== {2'b10, 32'h0000_0048}) begin
         errors++;
         $display("FAIL b2b_jalr_x0 got v=%b we=%b data=%h expected 1 0 00000048", wb_valid, wb_we, wb_data);
      end
      step();
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b1;
      set_op(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 5'd8);
      step();
      ex_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, wb_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rst_in_req got req=%b v=%b expected 0 0", mem_req, wb_valid);
      end
      step();
      rst_n = 1'b1;
      set_op(OP_LOAD, 3'b010, 32'h0000_0504, 32'h0, 32'h0, 5'd8);
      step();
      ex_valid = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, wb_valid, ex_ready} !== 3'b001) begin
         errors++;
         $display("FAIL rst_in_wait got req=%b v=%b ex_ready=%b expected 0 0 1", mem_req, wb_valid, ex_ready);
      end
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      step();
      mem_rvalid = 1'b0;
      checks++;
      if ({wb_valid, mem_req} !== 2'b00) begin
         errors++;
         $display("FAIL rst_late_rvalid got v=%b req=%b expected 0 0", wb_valid, mem_req);
      end
      set_op(OP_ALU, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 5'd2);
      step();
      ex_valid = 1'b0;
      checks++;
      if ({wb_valid, wb_we, wb_fault, wb_rd, wb_data} !== {3'b110, 5'd2, 32'h0000_0077}) begin
         errors++;
         $display("FAIL rst_clean_op got v=%b we=%b f=%b rd=%0d data=%h expected 1 1 0 2 00000077",
                  wb_valid, wb_we, wb_fault, wb_rd, wb_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_byte();
      test_store_lanes();
      test_load_ext(3'b000, 32'hFFFF_FF80);
      test_load_ext(3'b100, 32'h0000_0080);
      test_fault();
      test_load_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
